// File: rtl/sigma_cpu.sv
// sigma_cpu: microcoded 32-bit CPU core using the Xerox Sigma instruction format.
//
// A 256-word microcode ROM (instance uc_rom, array memory) steers a small datapath:
// program address P, instruction register C (o = C[1:7] opcode, r = C[8:11] register),
// accumulator A, operand D and a 16x32 register file RR. One microword executes per clock.
// Bit numbering is big-endian throughout ([0] = MSB).
//
// Ports:
//   clock    in   single rising-edge clock
//   reset    in   synchronous, active-high reset
//   data_in  in   [0:31] memory read data, combinational from address
//   address  out  [0:16] word address to memory
//
// Microword layout:
//   [0:2] SEQ  [3:4] ASRC  [5:7] AOP  [8:9] DOP  [10] RR[r]<=A  [11] C<=data_in
//   [12] P<=P+1  [13] P<=address mux  [16:23] NEXT  [14:15],[24:31] ignored
//
// Optional feature: define CPU_TRACE_EN to print "P=%h C=%h A=%h" on every
// end-of-instruction edge. Without it no trace logic is present.

module uc_rom #(
  parameter int unsigned UC_DEPTH = 256
) (
  input  logic [0:7]  addr,
  output logic [0:31] data
);

  // Contents are loaded from outside (the simulation bench writes this array directly).
  logic [0:31] memory [0:UC_DEPTH-1];

  assign data = memory[addr];

endmodule

module sigma_cpu #(
  parameter int unsigned UC_DEPTH = 256,
  parameter logic [0:16] RESET_PC = 17'h00000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] data_in,
  output logic [0:16] address
);

  typedef enum logic [2:0] {
    SeqInc      = 3'd0,
    SeqJump     = 3'd1,
    SeqDispatch = 3'd2,
    SeqIfZero   = 3'd3,
    SeqIfNeg    = 3'd4,
    SeqEnd      = 3'd5
  } seq_e;

  // Architecturally visible state.
  logic [0:7]  uPC;
  logic [15:31] P;
  logic [0:31] C;
  logic [0:31] A;
  logic [0:31] D;
  logic [0:31] RR [0:15];
  logic [0:6]  o;
  logic [0:3]  r;
  logic        ende;

  logic [0:31] uw;
  logic [2:0]  seq;
  logic [1:0]  asrc;
  logic [2:0]  aop;
  logic [1:0]  dop;
  logic        rr_we, c_ld, p_inc, p_ld;
  logic [0:7]  nxt;
  logic [0:16] addr_mux;

  logic [0:7]  upc_d;
  logic [15:31] p_d;
  logic [0:31] c_d, a_d, d_d;
  logic [0:31] rr_rd;

  logic unused_uw_bits;
  assign unused_uw_bits = ^{uw[14:15], uw[24:31]};

  uc_rom #(
    .UC_DEPTH(UC_DEPTH)
  ) uc_rom (
    .addr(uPC),
    .data(uw)
  );

  assign seq   = uw[0:2];
  assign asrc  = uw[3:4];
  assign aop   = uw[5:7];
  assign dop   = uw[8:9];
  assign rr_we = uw[10];
  assign c_ld  = uw[11];
  assign p_inc = uw[12];
  assign p_ld  = uw[13];
  assign nxt   = uw[16:23];

  assign o     = C[1:7];
  assign r     = C[8:11];
  assign rr_rd = RR[r];

  always_comb begin
    addr_mux = P;
    unique case (asrc)
      2'd1:    addr_mux = C[15:31];
      2'd2:    addr_mux = D[15:31];
      default: addr_mux = P;
    endcase
  end

  // Reset overrides the microword so memory and bench see a clean fetch address and no END.
  assign address = reset ? RESET_PC : addr_mux;
  assign ende    = !reset && (seq == SeqEnd);

  always_comb begin
    upc_d = uPC + 8'd1;
    unique case (seq)
      SeqJump:     upc_d = nxt;
      SeqDispatch: upc_d = {1'b1, o};
      SeqIfZero:   if (A == 32'd0) upc_d = nxt;
      SeqIfNeg:    if (A[0]) upc_d = nxt;
      SeqEnd:      upc_d = 8'd0;
      default:     upc_d = uPC + 8'd1;
    endcase
  end

  always_comb begin
    a_d = A;
    unique case (aop)
      3'd1:    a_d = data_in;
      3'd2:    a_d = rr_rd;
      3'd3:    a_d = A + D;
      3'd4:    a_d = A - D;
      3'd5:    a_d = A & D;
      3'd6:    a_d = A | D;
      3'd7:    a_d = A ^ D;
      default: a_d = A;
    endcase
  end

  always_comb begin
    d_d = D;
    unique case (dop)
      2'd1:    d_d = data_in;
      2'd2:    d_d = rr_rd;
      2'd3:    d_d = {{12{C[12]}}, C[12:31]};
      default: d_d = D;
    endcase
  end

  always_comb begin
    c_d = c_ld ? data_in : C;
    p_d = P;
    if (p_ld) begin
      p_d = addr_mux;
    end else if (p_inc) begin
      p_d = P + 17'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uPC <= 8'd0;
      P   <= RESET_PC;
      C   <= 32'd0;
      A   <= 32'd0;
      D   <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        RR[i] <= 32'd0;
      end
    end else begin
      uPC <= upc_d;
      P   <= p_d;
      C   <= c_d;
      A   <= a_d;
      D   <= d_d;
      // Stores the pre-edge A, so an ALU op in the same word does not affect the store.
      if (rr_we) begin
        RR[r] <= A;
      end
    end
  end

`ifdef CPU_TRACE_EN
  always @(posedge clock) begin
    if (ende && !reset) begin
      $display("P=%h C=%h A=%h", P, C, A);
    end
  end
`else
`endif

endmodule

// File: tb/tb_sigma_cpu.sv
// Directed bench for sigma_cpu: microcode and memory images are hand-built per test,
// expected register values are hand-computed constants.

module tb_sigma_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [0:31] data_in;
  logic [0:16] address;

  logic [0:31] mem [0:255];
  logic        unused_addr_hi;

  int n_vec = 0;
  int n_bad = 0;

  sigma_cpu cpu (
    .clock  (clock),
    .reset  (reset),
    .data_in(data_in),
    .address(address)
  );

  always #5 clock = ~clock;

  assign data_in        = mem[address[9:16]];
  assign unused_addr_hi = |address[0:8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:31] uw(input int seq, input int asrc, input int aop, input int dop,
                                     input int wrr, input int ldc, input int incp, input int ldp,
                                     input int nxt);
    logic [2:0] s;
    logic [1:0] a;
    logic [2:0] ao;
    logic [1:0] d;
    logic [7:0] n;
    s  = seq[2:0];
    a  = asrc[1:0];
    ao = aop[2:0];
    d  = dop[1:0];
    n  = nxt[7:0];
    return {s, a, ao, d, wrr[0], ldc[0], incp[0], ldp[0], 2'b00, n, 8'h00};
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 256; i++) begin
      cpu.uc_rom.memory[i] = 32'd0;
      mem[i] = 32'd0;
    end
  endtask

  // Fetch: C<=data_in, P++, jump to 1; then dispatch on o. WAIT (o=46) loops at 174.
  task automatic load_fetch();
    cpu.uc_rom.memory[0]   = uw(1, 0, 0, 0, 0, 1, 1, 0, 1);
    cpu.uc_rom.memory[1]   = uw(2, 0, 0, 0, 0, 0, 0, 0, 0);
    cpu.uc_rom.memory[174] = uw(1, 0, 0, 0, 0, 0, 0, 0, 174);
  endtask

  // o=0x11: D<=imm, A<=RR[r], A<=A+D, RR[r]<=A with END.
  task automatic load_add();
    cpu.uc_rom.memory[145] = uw(0, 0, 0, 3, 0, 0, 0, 0, 0);
    cpu.uc_rom.memory[146] = uw(0, 0, 2, 0, 0, 0, 0, 0, 0);
    cpu.uc_rom.memory[147] = uw(0, 0, 3, 0, 0, 0, 0, 0, 0);
    cpu.uc_rom.memory[148] = uw(5, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Reset: an END word at uPC 0 must not raise ende while reset is held.
    clear_all();
    cpu.uc_rom.memory[0] = uw(5, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ende_held", 32'(cpu.ende), 32'd0);
    check("rst_addr_held", 32'(address), 32'd0);
    cpu.uc_rom.memory[0] = 32'd0;
    reset = 1'b0;
    #1;
    check("rst_addr", 32'(address), 32'd0);
    check("rst_upc", 32'(cpu.uPC), 32'd0);
    check("rst_o", 32'(cpu.o), 32'd0);
    check("rst_ende", 32'(cpu.ende), 32'd0);
    check("rst_a", cpu.A, 32'd0);

    // Fetch and dispatch to WAIT.
    clear_all();
    load_fetch();
    mem[0] = 32'h2E000000;
    do_reset();
    step(2);
    check("fd_o", 32'(cpu.o), 32'd46);
    check("fd_p", 32'(cpu.P), 32'd1);
    check("fd_upc", 32'(cpu.uPC), 32'd174);
    check("fd_c", cpu.C, 32'h2E000000);
    step(3);
    check("fd_wait_loop", 32'(cpu.uPC), 32'd174);

    // Two add-immediate instructions on r=3: 0+7 then 7+5.
    clear_all();
    load_fetch();
    load_add();
    mem[0] = 32'h11300007;
    mem[1] = 32'h11300005;
    mem[2] = 32'h2E000000;
    do_reset();
    step(5);
    check("add1_upc", 32'(cpu.uPC), 32'd148);
    check("add1_ende", 32'(cpu.ende), 32'd1);
    check("add1_a", cpu.A, 32'd7);
    step(1);
    check("add1_rr3", cpu.RR[3], 32'd7);
    check("add1_ende_off", 32'(cpu.ende), 32'd0);
    check("add1_upc0", 32'(cpu.uPC), 32'd0);
    step(5);
    check("add2_ende", 32'(cpu.ende), 32'd1);
    check("add2_a", cpu.A, 32'd12);
    check("add2_d", cpu.D, 32'd5);
    step(1);
    check("add2_rr3", cpu.RR[3], 32'd12);
    check("add2_upc0", 32'(cpu.uPC), 32'd0);
    check("add2_ende_off", 32'(cpu.ende), 32'd0);
    check("add2_p", 32'(cpu.P), 32'd2);

    // Branch via C[15:31]; P load wins over P++ in the same word.
    clear_all();
    load_fetch();
    cpu.uc_rom.memory[176] = uw(5, 1, 0, 0, 0, 0, 1, 1, 0);
    mem[0]    = 32'h30000040;
    mem[8'h40] = 32'h2E000000;
    do_reset();
    step(2);
    check("br_upc", 32'(cpu.uPC), 32'd176);
    check("br_addr_mux", 32'(address), 32'h40);
    check("br_ende", 32'(cpu.ende), 32'd1);
    step(1);
    check("br_p", 32'(cpu.P), 32'h40);
    check("br_fetch_addr", 32'(address), 32'h40);
    step(2);
    check("br_o", 32'(cpu.o), 32'd46);
    check("br_p_next", 32'(cpu.P), 32'h41);

    // Conditional: A==0 takes NEXT.
    clear_all();
    cpu.uc_rom.memory[0] = uw(3, 0, 0, 0, 0, 0, 0, 0, 8'h50);
    do_reset();
    step(1);
    check("cz_taken", 32'(cpu.uPC), 32'h50);

    // A==1 falls through; unused SEQ 6 behaves as uPC+1.
    clear_all();
    cpu.uc_rom.memory[0] = uw(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cpu.uc_rom.memory[1] = uw(3, 0, 0, 0, 0, 0, 0, 0, 8'h50);
    cpu.uc_rom.memory[2] = uw(6, 0, 0, 0, 0, 0, 0, 0, 8'h50);
    mem[0] = 32'd1;
    do_reset();
    step(2);
    check("cz_a", cpu.A, 32'd1);
    check("cz_fall", 32'(cpu.uPC), 32'd2);
    step(1);
    check("seq6_inc", 32'(cpu.uPC), 32'd3);

    // Sign-bit branch, then uPC wrap 255 -> 0.
    clear_all();
    cpu.uc_rom.memory[0]     = uw(0, 0, 1, 0, 0, 0, 0, 0, 0);
    cpu.uc_rom.memory[1]     = uw(4, 0, 0, 0, 0, 0, 0, 0, 8'h50);
    cpu.uc_rom.memory[8'h50] = uw(1, 0, 0, 0, 0, 0, 0, 0, 255);
    mem[0] = 32'h80000000;
    do_reset();
    step(2);
    check("cn_taken", 32'(cpu.uPC), 32'h50);
    step(1);
    check("upc_255", 32'(cpu.uPC), 32'd255);
    step(1);
    check("upc_wrap", 32'(cpu.uPC), 32'd0);

    // Reset in the middle of the add sequence.
    clear_all();
    load_fetch();
    load_add();
    mem[0] = 32'h11300007;
    do_reset();
    step(4);
    check("mr_upc_before", 32'(cpu.uPC), 32'd147);
    reset = 1'b1;
    #1;
    check("mr_addr_forced", 32'(address), 32'd0);
    check("mr_ende_forced", 32'(cpu.ende), 32'd0);
    step(1);
    check("mr_upc", 32'(cpu.uPC), 32'd0);
    check("mr_a", cpu.A, 32'd0);
    check("mr_p", 32'(cpu.P), 32'd0);
    check("mr_d", cpu.D, 32'd0);
    check("mr_c", cpu.C, 32'd0);
    reset = 1'b0;
    step(3);
    check("mr_no_ende", 32'(cpu.ende), 32'd0);
    check("mr_rr3", cpu.RR[3], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
